// File: rtl/fir_capture_pkg.sv
// ============================================================================
// Module  : fir_capture_pkg
// Brief   : Shared constants and FSM state type for the FIR capture buffer.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_capture_pkg;

    localparam int DATA_W_DEF = 12;
    localparam int DEPTH_DEF  = 1024;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        READOUT = 2'd3
    } cap_state_t;

endpackage

`default_nettype wire

// File: rtl/fir_capture_if.sv
// ============================================================================
// Module  : fir_capture_if
// Brief   : Valid/ready readout stream carrying captured samples.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface fir_capture_if #(
    parameter int DATA_W = 12
) ();

    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_ready;
    logic              rd_last;

    modport master (output rd_data, output rd_valid, output rd_last, input rd_ready);
    modport slave  (input rd_data, input rd_valid, input rd_last, output rd_ready);

endinterface

`default_nettype wire

// File: rtl/fir_capture_ram.sv
// ============================================================================
// Module  : capture_ram
// Brief   : Simple dual-port sample store, one write port, one registered read.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module capture_ram #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic              clk,
    input  wire logic              i_we,
    input  wire logic [ADDR_W-1:0] i_waddr,
    input  wire logic [DATA_W-1:0] i_wdata,
    input  wire logic              i_re,
    input  wire logic [ADDR_W-1:0] i_raddr,
    output logic      [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // No reset on the array or the read register so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) o_rdata <= r_mem[i_raddr];
    end

endmodule

`default_nettype wire

// File: rtl/fir_capture.sv
// ============================================================================
// Module  : fir_capture
// Brief   : Armed/triggered capture of DEPTH FIR samples, drained over a stream.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fir_capture
    import fir_capture_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic signed [DATA_W-1:0] sample_in,
    input  wire logic                     sample_valid,
    input  wire logic                     arm,
    input  wire logic                     abort,
    input  wire logic                     trig_mode,
    input  wire logic signed [DATA_W-1:0] trig_level,
    fir_capture_if.master                 rd,
    output logic                          busy,
    output logic                          done
);

    localparam logic [ADDR_W-1:0] c_LAST_IDX = ADDR_W'(DEPTH - 1);

    cap_state_t               r_state, w_state_nxt;
    logic [ADDR_W-1:0]        r_wr_ptr;
    logic                     r_trig_mode;
    logic signed [DATA_W-1:0] r_trig_level;
    logic signed [DATA_W-1:0] r_prev;
    logic                     r_prev_vld;

    logic [ADDR_W:0]          r_rd_addr;
    logic                     r_s1_vld;
    logic                     r_s1_last;
    logic [DATA_W-1:0]        r_rd_data;
    logic                     r_rd_valid;
    logic                     r_rd_last;
    logic                     r_done;

    logic                     w_trig;
    logic                     w_we;
    logic [ADDR_W-1:0]        w_waddr;
    logic                     w_re;
    logic                     w_out_load;
    logic                     w_last_hs;
    logic [DATA_W-1:0]        w_ram_rdata;

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_trig      = 1'b0;
        w_we        = 1'b0;
        w_waddr     = r_wr_ptr;
        w_last_hs   = r_rd_valid && rd.rd_ready && r_rd_last;
        w_out_load  = r_s1_vld && (!r_rd_valid || rd.rd_ready);
        // Keep the RAM stage full whenever the output register can drain it.
        w_re        = (r_state == READOUT) && !r_rd_addr[ADDR_W] && (!r_s1_vld || w_out_load);
        case (r_state)
            IDLE: begin
                if (arm) w_state_nxt = ARMED;
            end
            ARMED: begin
                if (sample_valid) begin
                    w_trig = !r_trig_mode ||
                             (r_prev_vld && (r_prev < r_trig_level) && (sample_in >= r_trig_level));
                    if (w_trig) begin
                        w_we        = 1'b1;
                        w_waddr     = '0;
                        w_state_nxt = CAPTURE;
                    end
                end
            end
            CAPTURE: begin
                if (sample_valid) begin
                    w_we = 1'b1;
                    if (r_wr_ptr == c_LAST_IDX) w_state_nxt = READOUT;
                end
            end
            READOUT: begin
                if (w_last_hs) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        if (abort) w_state_nxt = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr     <= '0;
            r_trig_mode  <= 1'b0;
            r_trig_level <= '0;
            r_prev       <= '0;
            r_prev_vld   <= 1'b0;
        end else begin
            if (r_state == IDLE && arm && !abort) begin
                r_trig_mode  <= trig_mode;
                r_trig_level <= trig_level;
                r_wr_ptr     <= '0;
                r_prev_vld   <= 1'b0;
            end else if (r_state == ARMED && sample_valid && !w_trig) begin
                r_prev     <= sample_in;
                r_prev_vld <= 1'b1;
            end
            if (w_we && w_waddr != c_LAST_IDX) r_wr_ptr <= w_waddr + 1'b1;
        end
    end

    capture_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (sample_in),
        .i_re    (w_re),
        .i_raddr (r_rd_addr[ADDR_W-1:0]),
        .o_rdata (w_ram_rdata)
    );

    // Two-stage read pipe: RAM output stage (s1) feeding the held output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_addr  <= '0;
            r_s1_vld   <= 1'b0;
            r_s1_last  <= 1'b0;
            r_rd_data  <= '0;
            r_rd_valid <= 1'b0;
            r_rd_last  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= w_last_hs && !abort;
            if (r_state != READOUT || abort) begin
                r_rd_addr  <= '0;
                r_s1_vld   <= 1'b0;
                r_rd_valid <= 1'b0;
                r_rd_last  <= 1'b0;
            end else begin
                if (w_re) begin
                    r_rd_addr <= r_rd_addr + 1'b1;
                    r_s1_vld  <= 1'b1;
                    r_s1_last <= (r_rd_addr[ADDR_W-1:0] == c_LAST_IDX);
                end else if (w_out_load) begin
                    r_s1_vld <= 1'b0;
                end
                if (w_out_load) begin
                    r_rd_data  <= w_ram_rdata;
                    r_rd_valid <= 1'b1;
                    r_rd_last  <= r_s1_last;
                end else if (rd.rd_ready) begin
                    r_rd_valid <= 1'b0;
                    r_rd_last  <= 1'b0;
                end
            end
        end
    end

    assign rd.rd_data  = r_rd_data;
    assign rd.rd_valid = r_rd_valid;
    assign rd.rd_last  = r_rd_last;
    assign busy        = (r_state != IDLE);
    assign done        = r_done;

endmodule

`default_nettype wire

// File: doc/fir_capture.md
# fir_capture

Post-filter capture buffer for the 12-bit FIR datapath. It records a block of DEPTH signed filter-output samples after an arm command and an optional level trigger. It then drains them in order over a valid/ready stream for off-chip logging or software readback. It sits directly on the FIR `signal_out` bus as the consumer of that output.

## Interface
- `DATA_W`, 12: sample width, two's complement.
- `DEPTH`, 1024: samples per capture; power of two, ≥4.
- `ADDR_W`, $clog2(DEPTH): RAM address width.

- Clock and reset: one clock; reset is synchronous and active-high. Port names are `clk` and `rst`.
- `clk`  in  1  system clock, 50 MHz.
- `rst`  in  1  synchronous, active-high reset.
- `sample_in`  in  DATA_W  signed FIR output sample.
- `sample_valid`  in  1  `sample_in` is a new sample this cycle.
- `arm`  in  1  single-cycle pulse that starts a capture; honoured only in IDLE.
- `abort`  in  1  return to IDLE from any state.
- `trig_mode`  in  1  0 = immediate, 1 = rising level crossing; sampled on `arm`.
- `trig_level`  in  DATA_W  signed threshold; sampled on `arm`.
- `rd_data`  out  DATA_W  captured sample.
- `rd_valid`  out  1  `rd_data` is valid.
- `rd_ready`  in  1  consumer accepts `rd_data`.
- `rd_last`  out  1  marks the final sample (index DEPTH-1).
- `busy`  out  1  state ≠ IDLE.
- `done`  out  1  one-cycle pulse after the last beat is accepted.

## Operation
- States and transitions:
  - IDLE → ARMED on `arm`.
  - ARMED → CAPTURE on trigger.
  - CAPTURE → READOUT after DEPTH writes.
  - READOUT → IDLE after the handshake of the last beat.
- `abort` (any state) → IDLE on the next edge; no `done` pulse. `abort` has priority over all other events.
- On `arm`, `trig_mode` and `trig_level` are latched, the write pointer is cleared, and the prev-valid flag is cleared.
- Immediate mode: the first valid sample in ARMED is the trigger and is written to address 0.
- Crossing mode: trigger when `prev < trig_level` and `sample_in >= trig_level`.
  - The comparison is signed, full DATA_W.
  - `prev` is the previous valid sample seen in ARMED.
  - The first valid sample after `arm` only loads `prev` and cannot trigger.
- The triggering sample is always written at address 0.
- CAPTURE:
  - Each valid sample is written at `wr_ptr`, then `wr_ptr` increments.
  - Gaps in `sample_valid` stall capture.
  - After the write at DEPTH-1, go to READOUT; the pointer is not wrapped.
- READOUT:
  - Synchronous RAM read with one output register.
  - Read address is prefetched so that back-to-back handshakes give one sample per cycle.
  - `rd_data` is held stable while `rd_valid && !rd_ready`.
- `sample_valid` is ignored in IDLE and READOUT.
- `arm` outside IDLE is ignored.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `rd_last`=0, `busy`=0, `done`=0. State = IDLE, pointers = 0. RAM contents are not cleared.
- A sample is captured at the posedge where `sample_valid`=1.
- `busy` rises the cycle after `arm` is seen.
- Trigger detection is registered-free: the trigger sample is written on the same edge that the state moves to CAPTURE.
- `rd_valid` first rises 2 cycles after entering READOUT (RAM read plus output register).
- With `rd_ready`=1 continuously, a drain takes exactly DEPTH consecutive `rd_valid` cycles.
- `rd_last`=1 only together with `rd_valid` on index DEPTH-1.
- `done`:
  - Pulses in the cycle after the last handshake.
  - State is IDLE and `busy`=0 in that same cycle.
  - A new `arm` is accepted in that cycle.
- `rst` or `abort` mid-READOUT drops `rd_valid` on the next edge.
- No partial-transfer guarantee.

## Structure
- Package `fir_capture_pkg`:
  - State enum `cap_state_t` {IDLE, ARMED, CAPTURE, READOUT}.
  - `DATA_W_DEF`=12 and `DEPTH_DEF`=1024 constants.
- Sub-module `capture_ram`: simple dual-port, one write port, one synchronous-read port, DEPTH×DATA_W, no reset. It is inferred as block RAM.
- FSM, pointers, trigger compare and the output register live in `fir_capture`.

## Test plan
- Immediate trigger, DEPTH=16, continuous valid ramp 0..15 in signed, `rd_ready`=1 → `rd_data` 0..15 on 16 consecutive cycles; `rd_last` on 15; `done` one cycle later.
- Crossing trigger, `trig_level`=100, input −50, 20, 99, 100, 150… → first stored sample is 100. Input 100 appearing as the first sample after `arm` must not trigger.
- Negative threshold `trig_level`=−200, input −300 → −200 → triggers on −200. Signed compare checked with input 2047 → −2048 (no trigger).
- `sample_valid` toggling 1/0 during CAPTURE → exactly DEPTH samples stored, no duplicates. `rd_ready` random 50% → order preserved and `rd_data` stable while stalled.
- `abort` mid-CAPTURE, then `arm` mid-READOUT of a fresh run:
  - After `abort`: IDLE next cycle, `busy`=0, no `done`.
  - `arm` mid-READOUT is ignored.
- `rst` asserted mid-READOUT with `rd_valid`=1 → all outputs 0 next cycle. A new capture afterwards returns correct data.
